mem_block_ctrl: RTL

Block-transfer controller that sits directly upstream of the word-wide simulated main memory. It sits between a cache and that memory. On a cache miss it optionally writes back a dirty victim block, then fills the requested block. Each word of a block is moved as one memory transaction over the memory's re/we/Valid handshake. The filled block is returned to the cache as one wide register with a one-cycle Done pulse.

---
 rtl/mem_block_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/mem_block_ctrl.sv
// Block-transfer controller between a cache and word-wide main memory:
// optional dirty-victim writeback, then block fill, one memory transaction per word.
module mem_block_ctrl #(
  parameter int blocksize = 4,
  localparam int idxBits = $clog2(blocksize)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      Start,
  input  logic                      Dirty,
  input  logic [31:0]               BlockAddr,
  input  logic [31:0]               VictimAddr,
  input  logic [32*blocksize-1:0]   VictimData,
  output logic                      Busy,
  output logic                      Done,
  output logic [32*blocksize-1:0]   FillData,
  output logic                      MemRE,
  output logic                      MemWE,
  output logic [31:0]               MemA,
  output logic [31:0]               MemWD,
  input  logic [31:0]               MemRD,
  input  logic                      MemValid
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL, DONE} state_t;

  state_t                   state, state_nx;
  logic [idxBits-1:0]       idx;
  logic [31-2-idxBits:0]    blk_tag, vic_tag;
  logic [32*blocksize-1:0]  vic_data;
  logic [idxBits+4:0]       wbase;
  logic                     last_word;
  logic                     unused_lsbs;

  assign last_word   = (idx == idxBits'(blocksize - 1));
  assign wbase       = {idx, 5'b00000};
  assign unused_lsbs = ^{BlockAddr[1+idxBits:0], VictimAddr[1+idxBits:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (Start) state_nx = Dirty ? WRITEBACK : FILL;
      WRITEBACK: if (MemValid && last_word) state_nx = FILL;
      FILL:      if (MemValid && last_word) state_nx = DONE;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Request lines are pure functions of state and idx, so they stay put until
  // the completing edge and the next word is presented in the following cycle.
  always_comb begin
    Busy  = (state != IDLE);
    Done  = 1'b0;
    MemRE = 1'b0;
    MemWE = 1'b0;
    MemA  = '0;
    MemWD = '0;
    case (state)
      WRITEBACK: begin
        MemWE = 1'b1;
        MemA  = {vic_tag, idx, 2'b00};
        MemWD = vic_data[wbase +: 32];
      end
      FILL: begin
        MemRE = 1'b1;
        MemA  = {blk_tag, idx, 2'b00};
      end
      DONE:    Done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx      <= '0;
      blk_tag  <= '0;
      vic_tag  <= '0;
      vic_data <= '0;
      FillData <= '0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          idx      <= '0;
          blk_tag  <= BlockAddr[31:2+idxBits];
          vic_tag  <= VictimAddr[31:2+idxBits];
          vic_data <= VictimData;
        end
        WRITEBACK: if (MemValid) idx <= last_word ? '0 : idx + 1'b1;
        FILL: if (MemValid) begin
          FillData[wbase +: 32] <= MemRD;
          idx <= last_word ? '0 : idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
